// File: rtl/fpu_pkg.sv
// fpu_pkg: shared encodings and defaults for the add/sub arbiter slice
// Contents: OP_ADD/OP_SUB op encodings, DEFAULT_LATENCY of the shared core,
//   tag_t carried alongside each operation through the core pipeline.
package fpu_pkg;
   localparam logic OP_ADD          = 1'b0;
   localparam logic OP_SUB          = 1'b1;
   localparam int   DEFAULT_LATENCY = 3;
   typedef struct packed {
      logic vld;
      logic id;
   } tag_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter with a last-grant pointer
// Ports: clk, arst_n (async active-low); req[1:0] requests; gnt[1:0] one-hot grant.
//   Every grant is an acceptance, so the pointer moves whenever gnt is non-zero.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       arst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   // last = 1 means requester 1 won most recently, so requester 0 wins a tie
   logic last;
   always_comb begin
      gnt[0] = req[0] & (~req[1] | last);
      gnt[1] = req[1] & (~req[0] | ~last);
   end
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) last <= 1'b1;
      else if (|gnt) last <= gnt[1];
   end
endmodule

// File: rtl/fpu_addsub_arbiter.sv
// fpu_addsub_arbiter: round-robin front end sharing one pipelined add/sub core between two requesters
// Ports: clk, arst_n (async active-low reset)
//   reqN_valid/reqN_ready/reqN_a/reqN_b/reqN_op : request handshake, N = 0,1
//   core_en/core_a/core_b/core_op               : issue to the shared core
//   core_r                                      : core result, LATENCY cycles after core_en is sampled
//   rspN_valid/rspN_data                        : result returned to requester N
//   busy                                        : an operation is in flight
//   perf_cnt0/perf_cnt1                         : saturating accepted-op counters when FPU_ARB_PERF_EN
//                                                 is defined, otherwise tied to 0
module fpu_addsub_arbiter
   import fpu_pkg::*;
#(
   parameter int REG_WIDTH = 32,
   parameter int LATENCY   = DEFAULT_LATENCY
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [REG_WIDTH-1:0] req0_a,
   input  logic [REG_WIDTH-1:0] req0_b,
   input  logic                 req0_op,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [REG_WIDTH-1:0] req1_a,
   input  logic [REG_WIDTH-1:0] req1_b,
   input  logic                 req1_op,
   output logic                 core_en,
   output logic [REG_WIDTH-1:0] core_a,
   output logic [REG_WIDTH-1:0] core_b,
   output logic                 core_op,
   input  logic [REG_WIDTH-1:0] core_r,
   output logic                 rsp0_valid,
   output logic [REG_WIDTH-1:0] rsp0_data,
   output logic                 rsp1_valid,
   output logic [REG_WIDTH-1:0] rsp1_data,
   output logic                 busy,
   output logic [15:0]          perf_cnt0,
   output logic [15:0]          perf_cnt1
);
   logic [1:0] gnt;
   logic       en_id;
   tag_t       tag [LATENCY];
   tag_t       tag_out;
   rr_arbiter_2 u_arb (
      .clk    (clk),
      .arst_n (arst_n),
      .req    ({req1_valid, req0_valid}),
      .gnt    (gnt)
   );
   // ready must read 0 while reset is held, even with requests pending
   assign req0_ready = arst_n & gnt[0];
   assign req1_ready = arst_n & gnt[1];
   assign tag_out    = tag[LATENCY-1];
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         core_en <= 1'b0;
         core_a  <= '0;
         core_b  <= '0;
         core_op <= OP_ADD;
         en_id   <= 1'b0;
      end else begin
         core_en <= |gnt;
         if (|gnt) begin
            core_a  <= gnt[1] ? req1_a  : req0_a;
            core_b  <= gnt[1] ? req1_b  : req0_b;
            core_op <= gnt[1] ? req1_op : req0_op;
            en_id   <= gnt[1];
         end
      end
   end
   // tag[0] loads from the core_en stage, so tag[LATENCY-1] is valid exactly
   // when core_r holds the matching result
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < LATENCY; i++) tag[i] <= '0;
      end else begin
         tag[0] <= '{vld: core_en, id: en_id};
         for (int i = 1; i < LATENCY; i++) tag[i] <= tag[i-1];
      end
   end
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp1_data  <= '0;
      end else begin
         rsp0_valid <= tag_out.vld & ~tag_out.id;
         rsp1_valid <= tag_out.vld &  tag_out.id;
         if (tag_out.vld & ~tag_out.id) rsp0_data <= core_r;
         if (tag_out.vld &  tag_out.id) rsp1_data <= core_r;
      end
   end
   always_comb begin
      busy = core_en;
      for (int i = 0; i < LATENCY; i++) busy = busy | tag[i].vld;
   end
`ifdef FPU_ARB_PERF_EN
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         perf_cnt0 <= '0;
         perf_cnt1 <= '0;
      end else begin
         if (gnt[0] && perf_cnt0 != 16'hFFFF) perf_cnt0 <= perf_cnt0 + 16'd1;
         if (gnt[1] && perf_cnt1 != 16'hFFFF) perf_cnt1 <= perf_cnt1 + 16'd1;
      end
   end
`else
   assign perf_cnt0 = '0;
   assign perf_cnt1 = '0;
`endif
endmodule
